mod10_resp_checker: RTL and testbench

- Synthesizable response checker that sits on the mod10 counter interface, alongside the DUV.
- Watches the same rst/mode/load/data_in stimulus the DUV sees and keeps a cycle-accurate expected value.
- Compares data_out every cycle and reports mismatches, illegal stimulus and running statistics.
- Reusable in simulation benches and as an on-chip self-check monitor.

---
 rtl/mod_pkg.sv | 31 +++
 rtl/sat_counter.sv | 25 ++
 rtl/mod10_resp_checker.sv | 123 ++++++++++++
 tb/tb_mod10_resp_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared definitions for the mod-10 counter response checker: state encoding,
// the legal-range limit and the single reference model of the counter contract.
package mod_pkg;

    localparam logic [3:0] MOD10_MAX = 4'd9;

    typedef enum logic [0:0] {
        TRACK  = 1'b0,
        RESYNC = 1'b1
    } chk_state_e;

    // Next count for a non-reset cycle; wraps are explicit so a 4-bit overflow never leaks through.
    function automatic logic [3:0] mod_next(
        input logic [3:0] cur,
        input logic       mode,
        input logic       load,
        input logic [3:0] din,
        input logic [3:0] max_val = MOD10_MAX
    );
        logic [3:0] nxt;
        if (load) begin
            nxt = din;
        end else if (mode) begin
            nxt = (cur == max_val) ? 4'd0 : cur + 4'd1;
        end else begin
            nxt = (cur == 4'd0) ? max_val : cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// clr has priority over inc and acts synchronously.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    // NOTE: non-blocking assignment keeps this register race-free against other always_ff readers.
    always_ff @(posedge clock) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mod10_resp_checker.sv
// Cycle-accurate response checker for a mod-10 up/down counter with parallel load.
// Mirrors the DUV stimulus, compares data_out every cycle and keeps error statistics.
module mod10_resp_checker
    import mod_pkg::*;
#(
    parameter int CW  = 16,
    parameter int MOD = 10
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          mode,
    input  logic          load,
    input  logic [3:0]    data_in,
    input  logic [3:0]    data_out,
    output logic [3:0]    expected,
    output logic          mismatch,
    output logic          illegal_stim,
    output logic          err_sticky,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] check_count,
    output logic          tracking
);

    localparam logic [3:0] LP_MAX = 4'(MOD - 1);

    chk_state_e r_state;
    chk_state_e w_state_next;
    logic [3:0] r_expected;
    logic [3:0] w_expected_next;
    logic       r_mismatch;
    logic       r_illegal;
    logic       r_err_sticky;
    logic       w_illegal;
    logic       w_din_legal;
    logic       w_cmp_en;
    logic       w_bad;
    logic       w_err_inc;

    assign w_din_legal = (data_in <= LP_MAX);

    // Compare enable: off while rst is high and throughout RESYNC, on from the first
    // un-reset clock in TRACK, so the value loaded by reset is itself checked.
    assign w_cmp_en  = !rst && (r_state == TRACK);
    assign w_bad     = (data_out != r_expected) || (data_out > LP_MAX);
    assign w_err_inc = w_cmp_en && w_bad;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= TRACK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_illegal       = 1'b0;
        case (r_state)
            TRACK: begin
                if (load && !w_din_legal) begin
                    w_illegal       = 1'b1;
                    w_state_next    = RESYNC;
                    w_expected_next = data_in;
                end else begin
                    w_expected_next = mod_next(r_expected, mode, load, data_in, LP_MAX);
                end
            end
            RESYNC: begin
                // Model is untrusted here; only a load re-anchors it.
                if (load) begin
                    w_expected_next = data_in;
                    if (w_din_legal) begin
                        w_state_next = TRACK;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = TRACK;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_expected   <= 4'd0;
            r_mismatch   <= 1'b0;
            r_illegal    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_expected <= w_expected_next;
            r_mismatch <= w_err_inc;
            r_illegal  <= w_illegal;
            if (w_err_inc) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    sat_counter #(.CW(CW)) u_err_cnt (
        .clock (clock),
        .clr   (rst),
        .inc   (w_err_inc),
        .count (err_count)
    );

    sat_counter #(.CW(CW)) u_chk_cnt (
        .clock (clock),
        .clr   (rst),
        .inc   (w_cmp_en),
        .count (check_count)
    );

    assign expected     = r_expected;
    assign mismatch     = r_mismatch;
    assign illegal_stim = r_illegal;
    assign err_sticky   = r_err_sticky;
    assign tracking     = (r_state == TRACK);

endmodule

// File: tb/tb_mod10_resp_checker.sv
// Directed bench for mod10_resp_checker: a wide-counter instance and a CW=2 instance
// see identical stimulus, with data_out driven as a hand-scripted DUV response.
module tb_mod10_resp_checker;

    logic        clock = 1'b0;
    logic        rst;
    logic        mode;
    logic        load;
    logic [3:0]  data_in;
    logic [3:0]  data_out;

    logic [3:0]  expected;
    logic        mismatch;
    logic        illegal_stim;
    logic        err_sticky;
    logic [15:0] err_count;
    logic [15:0] check_count;
    logic        tracking;

    logic [3:0]  expected2;
    logic        mismatch2;
    logic        illegal2;
    logic        sticky2;
    logic [1:0]  err2;
    logic [1:0]  chk2;
    logic        tracking2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mod10_resp_checker #(.CW(16), .MOD(10)) u_dut (
        .clock        (clock),
        .rst          (rst),
        .mode         (mode),
        .load         (load),
        .data_in      (data_in),
        .data_out     (data_out),
        .expected     (expected),
        .mismatch     (mismatch),
        .illegal_stim (illegal_stim),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .check_count  (check_count),
        .tracking     (tracking)
    );

    mod10_resp_checker #(.CW(2), .MOD(10)) u_dut_cw2 (
        .clock        (clock),
        .rst          (rst),
        .mode         (mode),
        .load         (load),
        .data_in      (data_in),
        .data_out     (data_out),
        .expected     (expected2),
        .mismatch     (mismatch2),
        .illegal_stim (illegal2),
        .err_sticky   (sticky2),
        .err_count    (err2),
        .check_count  (chk2),
        .tracking     (tracking2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] dn_out [5];
        logic [3:0] dn_exp [5];
        dn_out = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        dn_exp = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};

        rst = 1'b1; mode = 1'b1; load = 1'b0; data_in = 4'd0; data_out = 4'd0;
        step();
        step();
        check("rst_expected", expected, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_illegal", illegal_stim, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_err_count", err_count, 0);
        check("rst_check_count", check_count, 0);
        check("rst_tracking", tracking, 1);

        // Count up through the 9 -> 0 wrap against a correct DUV.
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            data_out = 4'(i % 10);
            step();
            check("up_expected", expected, (i + 1) % 10);
            check("up_mismatch", mismatch, 0);
        end
        check("up_check_count", check_count, 12);
        check("up_err_count", err_count, 0);
        check("up_sticky", err_sticky, 0);
        check("cw2_check_sat", chk2, 3);

        // Load 3, count down through the 0 -> 9 wrap.
        mode = 1'b0; load = 1'b1; data_in = 4'd3; data_out = 4'd2;
        step();
        check("load3_expected", expected, 3);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_out = dn_out[i];
            step();
            check("dn_expected", expected, dn_exp[i]);
            check("dn_mismatch", mismatch, 0);
        end
        check("dn_check_count", check_count, 18);

        // Walk down to expected = 4, then present a wrong value of 5.
        for (int v = 8; v > 4; v--) begin
            data_out = 4'(v);
            step();
        end
        check("pre_err_expected", expected, 4);
        data_out = 4'd5;
        step();
        check("err_mismatch_pulse", mismatch, 1);
        check("err_count_1", err_count, 1);
        check("err_sticky_set", err_sticky, 1);
        data_out = 4'd3;
        step();
        check("err_mismatch_clear", mismatch, 0);
        check("err_count_hold", err_count, 1);
        data_out = 4'd2;
        step();
        check("err_sticky_hold", err_sticky, 1);
        check("err_check_count", check_count, 25);

        // Illegal load sends the checker into RESYNC; compares freeze.
        load = 1'b1; data_in = 4'd12; data_out = 4'd1;
        step();
        check("ill_pulse", illegal_stim, 1);
        check("ill_tracking", tracking, 0);
        check("ill_expected", expected, 12);
        check("ill_check_count", check_count, 26);
        load = 1'b0; data_out = 4'd12;
        step();
        check("rs_illegal_clear", illegal_stim, 0);
        check("rs_frozen_1", check_count, 26);
        load = 1'b1; data_in = 4'd15; data_out = 4'd13;
        step();
        check("rs_illegal_again", illegal_stim, 1);
        check("rs_still_resync", tracking, 0);
        load = 1'b0; data_out = 4'd0;
        step();
        step();
        check("rs_frozen_2", check_count, 26);
        check("rs_no_mismatch", mismatch, 0);
        check("rs_err_count", err_count, 1);
        load = 1'b1; data_in = 4'd7; mode = 1'b1;
        step();
        check("resync_tracking", tracking, 1);
        check("resync_expected", expected, 7);
        check("resync_no_cmp", check_count, 26);
        load = 1'b0; data_out = 4'd7;
        step();
        check("resume_check_count", check_count, 27);
        check("resume_mismatch", mismatch, 0);
        check("resume_expected", expected, 8);

        // Second error, then reset from inside RESYNC.
        data_out = 4'd0;
        step();
        check("err2_mismatch", mismatch, 1);
        check("err2_count", err_count, 2);
        load = 1'b1; data_in = 4'd10; data_out = 4'd9;
        step();
        check("err2_resync", tracking, 0);
        check("err2_count_hold", err_count, 2);
        load = 1'b0; rst = 1'b1;
        step();
        check("rrst_err_count", err_count, 0);
        check("rrst_sticky", err_sticky, 0);
        check("rrst_tracking", tracking, 1);
        check("rrst_expected", expected, 0);
        check("rrst_check_count", check_count, 0);
        check("rrst_cw2_err", err2, 0);
        step();
        check("rrst_hold_mismatch", mismatch, 0);
        check("rrst_hold_check", check_count, 0);

        // Five wrong responses: the CW=2 error counter saturates at 3.
        rst = 1'b0; mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_out = 4'd9;
            step();
            check("sat_mismatch", mismatch, 1);
        end
        check("sat_err_wide", err_count, 5);
        check("sat_err_cw2", err2, 3);
        check("sat_cw2_mismatch", mismatch2, 1);
        check("sat_cw2_sticky", sticky2, 1);
        check("sat_cw2_illegal", illegal2, 0);
        check("sat_cw2_tracking", tracking2, 1);
        check("sat_cw2_expected", expected2, 5);
        data_out = 4'd9;
        step();
        check("sat_err_cw2_hold", err2, 3);
        check("sat_err_wide_6", err_count, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
